toggle_req_sender: RTL

- Sender-side front end of the pulse-to-toggle clock-domain crossing, in the s_clk domain.
- Accepts single-cycle enable pulses with data from the producer and buffers them in a small FIFO.
- Presents one word at a time on a held-stable data bus, announced by a request toggle.
- Issues the next word only after the receiver's acknowledge toggle, synchronized into s_clk, matches the request. Back-to-back enables can therefore never be lost or merged in the crossing.

---
 rtl/toggle_req_if.sv | 28 ++
 rtl/toggle_req_sender.sv | 110 +++++++++++
 2 files changed

// File: rtl/toggle_req_if.sv
// Producer/receiver-facing signals of the toggle request sender.
// master = the sender itself, slave = whatever drives the push side and returns ack.
interface toggle_req_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
);
  logic                       in_en;
  logic [DATA_W-1:0]          in_data;
  logic                       req_toggle;
  logic [DATA_W-1:0]          req_data;
  logic                       ack_toggle;
  logic                       busy;
  logic [$clog2(DEPTH):0]     fifo_level;
  logic                       overflow;
  logic [CNT_W-1:0]           sent_count;
  logic [CNT_W-1:0]           drop_count;

  modport master (
    input  in_en, in_data, ack_toggle,
    output req_toggle, req_data, busy, fifo_level, overflow, sent_count, drop_count
  );

  modport slave (
    output in_en, in_data, ack_toggle,
    input  req_toggle, req_data, busy, fifo_level, overflow, sent_count, drop_count
  );
endinterface

// File: rtl/toggle_req_sender.sv
// Sender half of a pulse-to-toggle CDC: buffers pushes in a small FIFO and launches
// one word per request toggle, waiting for the synchronized ack toggle to match.
module toggle_req_sender #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic          s_clk,
  input  logic          rst,
  toggle_req_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t            state;
  logic              ack_s1, ack_s2;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              req_toggle_q, busy_q, overflow_q;
  logic [DATA_W-1:0] req_data_q;
  logic [CNT_W-1:0]  sent_q, drop_q;

  logic empty, full, pop, push, drop;

  // A pop frees a slot on the same edge, so a push into a full FIFO is still accepted then.
  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign pop   = (state == IDLE) && !empty;
  assign push  = bus.in_en && (!full || pop);
  assign drop  = bus.in_en && !push;

  // NOTE: non-blocking assignments let ack_s2 take the old ack_s1, forming a real two-stage synchronizer.
  always_ff @(posedge s_clk or negedge rst) begin
    if (!rst) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= bus.ack_toggle;
      ack_s2 <= ack_s1;
    end
  end

  // NOTE: storage has no reset; the level/pointers alone decide which entries are valid.
  always_ff @(posedge s_clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge s_clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      req_toggle_q <= 1'b0;
      req_data_q   <= '0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      sent_q       <= '0;
      drop_q       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + 1'b1;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            req_data_q   <= mem[rd_ptr];
            req_toggle_q <= ~req_toggle_q;
            busy_q       <= 1'b1;
            state        <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // req_data/req_toggle stay frozen here; the receiver samples them asynchronously.
          if (ack_s2 == req_toggle_q) begin
            busy_q <= 1'b0;
            sent_q <= sent_q + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_toggle = req_toggle_q;
  assign bus.req_data   = req_data_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_level = level;
  assign bus.overflow   = overflow_q;
  assign bus.sent_count = sent_q;
  assign bus.drop_count = drop_q;

endmodule
